// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction-fetch
// requester (I, read-only) and a data requester (D, read/write).
// At most one transaction is outstanding; ties are broken round-robin.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   i_req, i_addr                   fetch read request / address
//   i_gnt, i_rvalid, i_rdata        fetch accept pulse, read-valid pulse, data
//   d_req, d_we, d_addr, d_wdata    data request / write enable / address / wdata
//   d_gnt, d_rvalid, d_rdata        data accept pulse, read-valid pulse, data
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata            memory side; rdata valid MEM_LAT cycles
//                                   after the mem_en cycle
//   busy                            high while a transaction is outstanding
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_last_d;   // 1: last grant went to D
    logic       r_sel_d;    // current transaction belongs to D
    logic       r_we;       // current transaction is a write

    logic w_any;
    logic w_pick_d;

    assign w_any    = i_req | d_req;
    // D wins alone, or on a tie when I was granted last.
    assign w_pick_d = d_req & (~i_req | ~r_last_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_last_d  <= 1'b1;
            r_sel_d   <= 1'b0;
            r_we      <= 1'b0;
            i_gnt     <= 1'b0;
            i_rvalid  <= 1'b0;
            i_rdata   <= '0;
            d_gnt     <= 1'b0;
            d_rvalid  <= 1'b0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            // Pulse outputs and the memory command default low/zero so they
            // are only asserted in the single cycle that sets them.
            i_gnt     <= 1'b0;
            d_gnt     <= 1'b0;
            i_rvalid  <= 1'b0;
            d_rvalid  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;

            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state  <= S_ISSUE;
                        busy     <= 1'b1;
                        r_sel_d  <= w_pick_d;
                        r_last_d <= w_pick_d;
                        mem_en   <= 1'b1;
                        if (w_pick_d) begin
                            d_gnt     <= 1'b1;
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_we ? d_wdata : '0;
                            r_we      <= d_we;
                        end else begin
                            i_gnt     <= 1'b1;
                            mem_addr  <= i_addr;
                            r_we      <= 1'b0;
                        end
                    end
                end

                S_ISSUE: begin
                    // The ISSUE cycle is latency cycle 0; WAIT starts at 1.
                    r_state <= S_WAIT;
                    r_cnt   <= 4'd1;
                end

                S_WAIT: begin
                    if (r_cnt == LAT) begin
                        // mem_rdata is valid in this cycle.
                        r_state <= S_RESP;
                        r_cnt   <= 4'd0;
                        if (!r_we) begin
                            if (r_sel_d) begin
                                d_rdata  <= mem_rdata;
                                d_rvalid <= 1'b1;
                            end else begin
                                i_rdata  <= mem_rdata;
                                i_rvalid <= 1'b1;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end

                S_RESP: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
